// File: rtl/sum_stationary_pkg.sv
// Shared definitions for the sum-stationary datapath.
//   - Default widths for the operand path between memory and the processor.
//   - reader_state_t: control states of the input memory reader.
package sum_stationary_pkg;

  localparam int DEFAULT_INPUT_DATA_WIDTH             = 8;
  localparam int DEFAULT_N                            = 4;
  localparam int DEFAULT_MEMORY_ADDRESS_BITS          = 64;
  localparam int DEFAULT_PARALLEL_DATA_STREAMING_SIZE = 4;
  localparam int DEFAULT_MAX_MATRIX_LENGTH            = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } reader_state_t;

endpackage

// File: rtl/vector_fifo.sv
// Small circular FIFO holding whole N-wide vectors.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push, push_data  write one vector (ignored when full unless popping too)
//   pop              remove the head vector (ignored when empty)
//   head             current head vector (undefined contents while empty)
//   full, empty      occupancy flags
// A push and a pop in the same cycle are both honoured, even when full.
module vector_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                do_push;
  logic                do_pop;

  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one the pop frees this cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate its use, and
  // leaving it reset-free lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/input_memory_reader.sv
// Input memory reader: fetches K vectors of N elements starting at a base
// element address, P elements per memory beat, and streams them to the
// processor through a 2-vector buffer.
// Ports:
//   clk, reset                               clock, asynchronous active-low reset
//   instruction_valid/ready, address_input,
//   length_input                             controller instruction (base, K)
//   completed_valid/ready                    completion handshake
//   read_valid/ready, read_address           memory request (one outstanding)
//   read_data_valid, read_data               memory response beat (index 0 = lowest address)
//   data_valid/ready, data_streaming         vector to the processor
module input_memory_reader
  import sum_stationary_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH             = DEFAULT_INPUT_DATA_WIDTH,
  parameter int N                            = DEFAULT_N,
  parameter int MEMORY_ADDRESS_BITS          = DEFAULT_MEMORY_ADDRESS_BITS,
  parameter int PARALLEL_DATA_STREAMING_SIZE = DEFAULT_PARALLEL_DATA_STREAMING_SIZE,
  parameter int MAX_MATRIX_LENGTH            = DEFAULT_MAX_MATRIX_LENGTH,
  parameter int COUNTER_BITS                 = $clog2(N - 1 + 1),
  parameter int MEMORY_INPUT_COUNTER_BITS    = $clog2(MAX_MATRIX_LENGTH * N + 1)
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        instruction_valid,
  output logic                                                        instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                              address_input,
  input  logic [$clog2(MAX_MATRIX_LENGTH+1)-1:0]                      length_input,
  output logic                                                        completed_valid,
  input  logic                                                        completed_ready,
  output logic                                                        read_valid,
  input  logic                                                        read_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]                              read_address,
  input  logic                                                        read_data_valid,
  input  logic [PARALLEL_DATA_STREAMING_SIZE-1:0][INPUT_DATA_WIDTH-1:0] read_data,
  output logic                                                        data_valid,
  input  logic                                                        data_ready,
  output logic [N-1:0][INPUT_DATA_WIDTH-1:0]                          data_streaming
);

  localparam int P        = PARALLEL_DATA_STREAMING_SIZE;
  localparam int LEN_BITS = $clog2(MAX_MATRIX_LENGTH + 1);
  localparam int MIC_BITS = MEMORY_INPUT_COUNTER_BITS;

  reader_state_t                      state_q, state_d;
  logic                               started_q;
  logic [MEMORY_ADDRESS_BITS-1:0]     base_q;
  logic [LEN_BITS-1:0]                len_q;
  logic [MIC_BITS-1:0]                req_cnt_q;
  logic [LEN_BITS-1:0]                vec_cnt_q;
  logic                               in_flight_q;
  logic [COUNTER_BITS-1:0]            fill_idx_q;
  logic [N-1:0][INPUT_DATA_WIDTH-1:0] assembly_q, assembly_d;

  logic [MIC_BITS-1:0]                total_elems;
  logic                               accept_instr, read_fire, beat, vec_done;
  logic                               pop, last_pop, fifo_full, fifo_empty;
  logic [N*INPUT_DATA_WIDTH-1:0]      fifo_head;

  assign accept_instr = instruction_valid && instruction_ready;
  assign total_elems  = MIC_BITS'(len_q) * MIC_BITS'(N);
  assign read_fire    = read_valid && read_ready;
  // Beats with no request in flight (e.g. one issued before a reset) are dropped.
  assign beat         = read_data_valid && in_flight_q;
  assign vec_done     = beat && (fill_idx_q == COUNTER_BITS'(N - P));
  assign pop          = data_valid && data_ready;
  assign last_pop     = pop && (vec_cnt_q == len_q - LEN_BITS'(1));

  // Requests wait for FIFO room: since only responses push, a request issued
  // while the FIFO has room is guaranteed room when its beat completes a vector.
  assign read_valid   = (state_q == ACTIVE) && !in_flight_q &&
                        (req_cnt_q < total_elems) && !fifo_full;
  assign read_address = base_q + MEMORY_ADDRESS_BITS'(req_cnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would infer a latch.
  always_comb begin
    state_d           = state_q;
    instruction_ready = 1'b0;
    completed_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // started_q keeps ready low until the first clock after reset.
        instruction_ready = started_q;
        if (accept_instr) state_d = (length_input == '0) ? DONE : ACTIVE;
      end
      ACTIVE: if (last_pop) state_d = DONE;
      DONE: begin
        completed_valid = 1'b1;
        if (completed_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge the arriving beat into the vector under assembly; the merged value
  // is what gets pushed when the beat completes the vector.
  always_comb begin
    assembly_d = assembly_q;
    for (int j = 0; j < P; j++) begin
      assembly_d[COUNTER_BITS'(int'(fill_idx_q) + j)] = read_data[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q   <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      fill_idx_q  <= '0;
    end else begin
      started_q <= 1'b1;
      if (accept_instr) begin
        base_q      <= address_input;
        len_q       <= length_input;
        req_cnt_q   <= '0;
        vec_cnt_q   <= '0;
        in_flight_q <= 1'b0;
        fill_idx_q  <= '0;
      end else begin
        if (read_fire) begin
          req_cnt_q   <= req_cnt_q + MIC_BITS'(P);
          in_flight_q <= 1'b1;
        end else if (beat) begin
          in_flight_q <= 1'b0;
        end
        if (beat) fill_idx_q <= vec_done ? '0 : fill_idx_q + COUNTER_BITS'(P);
        if (pop)  vec_cnt_q  <= vec_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) assembly_q <= assembly_d;
  end

  vector_fifo #(
    .DEPTH (2),
    .WIDTH (N * INPUT_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vec_done),
    .push_data (assembly_d),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign data_valid     = !fifo_empty;
  // Masked so the stream reads zero while the buffer is empty or in reset.
  assign data_streaming = fifo_empty ? '0 : fifo_head;

  assert property (@(posedge clk) disable iff (!reset)
    accept_instr |-> (length_input <= LEN_BITS'(MAX_MATRIX_LENGTH)));

endmodule

// File: tb/tb_input_memory_reader.sv
module tb_input_memory_reader;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int P    = 2;
  localparam int AB   = 64;
  localparam int MAXK = 16;
  localparam int LB   = $clog2(MAXK + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 instruction_valid = 1'b0;
  logic                 instruction_ready;
  logic [AB-1:0]        address_input = '0;
  logic [LB-1:0]        length_input = '0;
  logic                 completed_valid;
  logic                 completed_ready = 1'b0;
  logic                 read_valid;
  logic                 read_ready = 1'b1;
  logic [AB-1:0]        read_address;
  logic                 read_data_valid = 1'b0;
  logic [P-1:0][W-1:0]  read_data = '0;
  logic                 data_valid;
  logic                 data_ready = 1'b1;
  logic [N-1:0][W-1:0]  data_streaming;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  input_memory_reader #(
    .INPUT_DATA_WIDTH             (W),
    .N                            (N),
    .MEMORY_ADDRESS_BITS          (AB),
    .PARALLEL_DATA_STREAMING_SIZE (P),
    .MAX_MATRIX_LENGTH            (MAXK)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .address_input     (address_input),
    .length_input      (length_input),
    .completed_valid   (completed_valid),
    .completed_ready   (completed_ready),
    .read_valid        (read_valid),
    .read_ready        (read_ready),
    .read_address      (read_address),
    .read_data_valid   (read_data_valid),
    .read_data         (read_data),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .data_streaming    (data_streaming)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: memory holds the low address byte at every element address;
  // vector v of a transfer covers elements base+v*N .. base+v*N+N-1.
  function automatic logic [7:0] low_byte(input logic [63:0] a);
    return a[7:0];
  endfunction

  function automatic logic [N*W-1:0] vec_at(input logic [63:0] base, input int v);
    logic [N-1:0][W-1:0] r;
    for (int e = 0; e < N; e++) r[e] = low_byte(base + 64'(v * N + e));
    return r;
  endfunction

  logic [N*W-1:0] exp_q[$];
  logic [N*W-1:0] got_q[$];
  logic [AB-1:0]  req_log[$];
  logic [AB-1:0]  tx_base = '0;
  int tx_reqs = 0, tx_pops = 0;
  int first_req_cyc = -1, first_dv_cyc = -1, last_pop_cyc = -1, hs_cyc = 0;

  // Memory model: one response beat, mem_latency cycles after acceptance.
  int            mem_latency = 1;
  bit            pend = 1'b0;
  logic [AB-1:0] pend_addr = '0;
  int            pend_wait = 0;

  always @(negedge clk) begin
    read_data_valid = 1'b0;
    for (int j = 0; j < P; j++) read_data[j] = 8'hEE;
    if (pend) begin
      if (pend_wait == 0) begin
        read_data_valid = 1'b1;
        for (int j = 0; j < P; j++) read_data[j] = low_byte(pend_addr + 64'(j));
        pend = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    if (reset && read_valid && read_ready) begin
      if (tx_reqs == 0) first_req_cyc = cyc;
      check("req_addr", read_address, tx_base + 64'(tx_reqs * P));
      req_log.push_back(read_address);
      tx_reqs++;
      pend      = 1'b1;
      pend_addr = read_address;
      pend_wait = mem_latency - 1;
    end
  end

  // Compare process: stalled requests hold, accepted vectors match the model,
  // and no vector appears when the model expects none.
  bit            prev_stall = 1'b0;
  logic [AB-1:0] prev_addr = '0;
  logic [N*W-1:0] exp_vec;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_read_valid", read_valid, 1);
        check("hold_read_address", read_address, prev_addr);
      end
      prev_stall = read_valid && !read_ready;
      prev_addr  = read_address;
      if (data_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("idle_data_valid", data_valid, 0);
      end else if (data_valid && data_ready) begin
        exp_vec = exp_q.pop_front();
        check("vector", data_streaming, exp_vec);
        got_q.push_back(data_streaming);
        tx_pops++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic start(input logic [63:0] addr, input int k);
    tx_base = addr;
    tx_reqs = 0;
    tx_pops = 0;
    first_req_cyc = -1;
    first_dv_cyc  = -1;
    req_log.delete();
    got_q.delete();
    for (int v = 0; v < k; v++) exp_q.push_back(vec_at(addr, v));
    @(posedge clk); #1;
    check("instr_ready_idle", instruction_ready, 1);
    instruction_valid = 1'b1;
    address_input     = addr;
    length_input      = LB'(k);
    @(posedge clk); #1;
    hs_cyc            = cyc;
    instruction_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int rise_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!completed_valid && n < 400);
    check({name, "_completed"}, completed_valid, 1);
    rise_cyc = cyc;
  endtask

  task automatic ack();
    @(posedge clk); #1 completed_ready = 1'b1;
    @(posedge clk); #1 completed_ready = 1'b0;
    check("ready_after_ack", instruction_ready, 1);
    check("completed_cleared", completed_valid, 0);
  endtask

  task automatic check_outputs_reset(input string name);
    check({name, "_instruction_ready"}, instruction_ready, 0);
    check({name, "_completed_valid"}, completed_valid, 0);
    check({name, "_read_valid"}, read_valid, 0);
    check({name, "_data_valid"}, data_valid, 0);
    check({name, "_read_address"}, read_address, 0);
    check({name, "_data_streaming"}, data_streaming, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int n;

    // Reset state
    #2 reset = 1'b0;
    #2 check_outputs_reset("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 check("ready_before_first_clock", instruction_ready, 0);
    @(posedge clk); #1 check("ready_after_first_clock", instruction_ready, 1);

    // Nominal: K=3 at 0x100, 1-cycle memory, processor always ready
    start(64'h100, 3);
    wait_done("nominal", rise);
    check("first_req_latency", first_req_cyc, hs_cyc);
    check("first_data_valid_latency", first_dv_cyc, hs_cyc + 4);
    check("completed_after_last_pop", rise, last_pop_cyc + 1);
    check("completed_cycle", rise, hs_cyc + 13);
    check("nominal_req_count", req_log.size(), 6);
    for (int i = 0; i < 6 && i < req_log.size(); i++)
      check("nominal_req_literal", req_log[i], 64'h100 + 64'(2 * i));
    check("nominal_pops", tx_pops, 3);
    if (got_q.size() == 3) begin
      check("nominal_vec0", got_q[0], 32'h03020100);
      check("nominal_vec1", got_q[1], 32'h07060504);
      check("nominal_vec2", got_q[2], 32'h0B0A0908);
    end
    ack();

    // Backpressure: two vectors buffered, then requests stop
    data_ready = 1'b0;
    start(64'h100, 3);
    repeat (30) @(negedge clk);
    check("bp_req_count", tx_reqs, 4);
    check("bp_data_valid", data_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_read_valid_low", read_valid, 0);
    end
    @(posedge clk); #1 data_ready = 1'b1;
    wait_done("backpressure", rise);
    check("bp_pops", tx_pops, 3);
    check("bp_model_drained", exp_q.size(), 0);
    if (got_q.size() == 3) check("bp_vec2", got_q[2], 32'h0B0A0908);
    ack();

    // Memory stall mid-vector
    start(64'h100, 3);
    n = 0;
    while (tx_reqs < 1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 read_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_read_valid", read_valid, 1);
    check("stall_read_address", read_address, 64'h102);
    read_ready = 1'b1;
    wait_done("stall", rise);
    check("stall_pops", tx_pops, 3);
    if (got_q.size() == 3) begin
      check("stall_vec0", got_q[0], 32'h03020100);
      check("stall_vec1", got_q[1], 32'h07060504);
      check("stall_vec2", got_q[2], 32'h0B0A0908);
    end
    ack();

    // Zero length
    start(64'h200, 0);
    repeat (3) @(negedge clk);
    check("zero_completed", completed_valid, 1);
    check("zero_instr_ready_low", instruction_ready, 0);
    repeat (4) @(negedge clk);
    check("zero_completed_held", completed_valid, 1);
    ack();
    check("zero_no_requests", tx_reqs, 0);

    // Reset mid-operation with a request in flight
    mem_latency = 4;
    start(64'h300, 2);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(tx_pops >= 1 && pend) && n < 200);
    check("reset_inflight_reached", pend, 1);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 check_outputs_reset("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("midreset_ready_low", instruction_ready, 0);
    n = 0;
    while (pend && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("late_beat_dropped", data_valid, 0);
    check("late_no_request", read_valid, 0);
    check("late_instr_ready", instruction_ready, 1);
    mem_latency = 1;
    start(64'h410, 1);
    wait_done("fresh", rise);
    check("fresh_pops", tx_pops, 1);
    check("fresh_reqs", tx_reqs, 2);
    if (got_q.size() == 1) check("fresh_vec", got_q[0], 32'h13121110);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
